// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter with a one-word hold register.
// data_1_en rises the cycle after a word completes; buffer_full stalls the hold, never the shifter.
module deserializer #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     serial_en,
  input  logic                     buffer_full,
  output logic [WIDTH-1:0]         data_1,
  output logic                     data_1_en,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {EMPTY, LOADED} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] next_word;
  logic             word_done;

  assign next_word = {shreg[WIDTH-2:0], serial_in};
  assign word_done = serial_en && (bit_count == LAST_BIT);
  assign busy      = (state == LOADED);
  assign data_1    = hold;
  // Combinational so a falling buffer_full drains in the same cycle.
  assign data_1_en = busy && !buffer_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      shreg     <= '0;
      hold      <= '0;
      bit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (serial_en) begin
        shreg     <= next_word;
        bit_count <= word_done ? '0 : bit_count + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (word_done) begin
            hold  <= next_word;
            state <= LOADED;
          end
        end
        LOADED: begin
          if (word_done) begin
            // A drain on this edge frees the slot for the new word; otherwise it is lost.
            if (data_1_en) hold <= next_word;
            else           overflow <= 1'b1;
          end else if (data_1_en) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (WIDTH=16) with a transfer monitor.
module tb_deserializer;

  logic        clk;
  logic        clk_on;
  logic        rst;
  logic        serial_in;
  logic        serial_en;
  logic        buffer_full;
  logic [15:0] data_1;
  logic        data_1_en;
  logic        busy;
  logic        overflow;
  logic [3:0]  bit_count;

  int          n_chk;
  int          n_pass;
  logic [15:0] xfer_q[$];

  deserializer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .serial_en  (serial_en),
    .buffer_full(buffer_full),
    .data_1     (data_1),
    .data_1_en  (data_1_en),
    .busy       (busy),
    .overflow   (overflow),
    .bit_count  (bit_count)
  );

  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (data_1_en) xfer_q.push_back(data_1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      serial_in = w[i];
      serial_en = 1'b1;
      tick();
    end
    serial_en = 1'b0;
  endtask

  task automatic check_xfer(input string tag, input int n, input logic [15:0] last);
    check({tag, "_n"}, xfer_q.size(), n);
    if (xfer_q.size() > 0) check({tag, "_val"}, xfer_q[xfer_q.size()-1], last);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    clk_on      = 1'b0;
    serial_in   = 1'b0;
    serial_en   = 1'b0;
    buffer_full = 1'b0;
    rst         = 1'b1;

    // Reset with no clock running
    #1 rst = 1'b0;
    #2;
    check("rst_data", data_1, 16'h0);
    check("rst_en", data_1_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", bit_count, 0);
    clk_on = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("idle_data", data_1, 16'h0);
    check("idle_busy", busy, 0);
    check("idle_en", data_1_en, 0);
    check("idle_cnt", bit_count, 0);

    // Basic word
    shift_bits(16'hA5C3, 15, 0);
    check("basic_data", data_1, 16'hA5C3);
    check("basic_en", data_1_en, 1);
    check("basic_busy", busy, 1);
    check("basic_cnt", bit_count, 0);
    tick();
    check("basic_en_off", data_1_en, 0);
    check("basic_busy_off", busy, 0);
    check_xfer("basic_xfer", 1, 16'hA5C3);

    // Backpressure
    buffer_full = 1'b1;
    shift_bits(16'h1234, 15, 0);
    for (int i = 0; i < 10; i++) begin
      check("bp_busy", busy, 1);
      check("bp_en", data_1_en, 0);
      check("bp_data", data_1, 16'h1234);
      tick();
    end
    buffer_full = 1'b0;
    #1;
    check("bp_release_en", data_1_en, 1);
    tick();
    check("bp_after_en", data_1_en, 0);
    check("bp_after_busy", busy, 0);
    check_xfer("bp_xfer", 2, 16'h1234);

    // Overflow
    buffer_full = 1'b1;
    shift_bits(16'h1111, 15, 0);
    check("ovf_pre", overflow, 0);
    shift_bits(16'h2222, 15, 0);
    check("ovf_set", overflow, 1);
    check("ovf_data", data_1, 16'h1111);
    check("ovf_busy", busy, 1);
    buffer_full = 1'b0;
    #1;
    check("ovf_rel_en", data_1_en, 1);
    tick();
    check("ovf_rel_busy", busy, 0);
    check("ovf_sticky", overflow, 1);
    repeat (2) tick();
    check_xfer("ovf_xfer", 3, 16'h1111);
    check("ovf_sticky2", overflow, 1);
    rst = 1'b0;
    #2;
    check("ovf_clr", overflow, 0);
    tick();
    rst = 1'b1;
    tick();

    // Same-edge drain and load
    buffer_full = 1'b1;
    shift_bits(16'h0F0F, 15, 0);
    shift_bits(16'hBEEF, 15, 1);
    serial_in   = 1'b1;
    serial_en   = 1'b1;
    buffer_full = 1'b0;
    #1;
    check("same_en", data_1_en, 1);
    check("same_old", data_1, 16'h0F0F);
    tick();
    serial_en = 1'b0;
    check("same_new", data_1, 16'hBEEF);
    check("same_busy", busy, 1);
    check("same_ovf", overflow, 0);
    check_xfer("same_xfer1", 4, 16'h0F0F);
    tick();
    check("same_done", busy, 0);
    check_xfer("same_xfer2", 5, 16'hBEEF);

    // Mid-word reset
    shift_bits(16'h007F, 6, 0);
    check("mid_cnt7", bit_count, 7);
    rst = 1'b0;
    #1;
    check("mid_cnt0", bit_count, 0);
    tick();
    rst = 1'b1;
    shift_bits(16'h00FF, 15, 0);
    check("mid_data", data_1, 16'h00FF);
    check("mid_busy", busy, 1);
    tick();
    check_xfer("mid_xfer", 6, 16'h00FF);
    check("mid_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
